// File: rtl/va_sep_alloc_pkg.sv
// Shared defaults and helpers for the separable VC allocator.
// Imported by the allocator top and its round-robin arbiter.
package va_sep_alloc_pkg;

    localparam int unsigned N_DEF = 5;
    localparam int unsigned V_DEF = 4;

    // Index width for an n-entry vector; never returns zero, so n=1 still gets a legal field.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/va_sep_alloc_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer moves only on upd.
// The pointer jumps to one past the winner, so the last winner becomes lowest priority.
module va_sep_alloc_rr_arb
    import va_sep_alloc_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req,
    input  logic         upd,
    output logic [W-1:0] gnt
);

    localparam int unsigned PW = idx_w(W);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_win_idx;
    logic          w_found;

    // NOTE: every output of this block gets a default before the loop, so no path can infer a latch.
    always_comb begin
        logic [PW:0] sum;
        gnt       = '0;
        w_win_idx = '0;
        w_found   = 1'b0;
        sum       = '0;
        for (int k = 0; k < int'(W); k++) begin
            sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(W)) sum = sum - (PW+1)'(W);
            if (!w_found && req[sum[PW-1:0]]) begin
                gnt[sum[PW-1:0]] = 1'b1;
                w_win_idx        = sum[PW-1:0];
                w_found          = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (upd && w_found) begin
            r_ptr <= (w_win_idx == PW'(W-1)) ? '0 : w_win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/va_sep_alloc.sv
// Separable input-first VC allocator with output-VC ownership tracking.
// Stage 1 picks one output VC per input VC, stage 2 picks one input VC per output VC; grants are registered.
module va_sep_alloc
    import va_sep_alloc_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    parameter  int unsigned V  = V_DEF,
    localparam int unsigned NV = N * V,
    localparam int unsigned IW = idx_w(NV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NV*NV-1:0] req_i,
    input  logic [NV-1:0]    release_i,
    output logic [NV-1:0]    gnt_valid_o,
    output logic [NV*IW-1:0] gnt_vc_o,
    output logic [NV-1:0]    out_busy_o,
    output logic [NV-1:0]    in_alloc_o
);

    logic [NV-1:0]    r_busy;
    logic [NV-1:0]    r_in_alloc;
    logic [IW-1:0]    r_owner [NV];
    logic [NV-1:0]    r_gnt_valid;
    logic [NV*IW-1:0] r_gnt_vc;

    logic [NV-1:0]    w_ereq    [NV];
    logic [NV-1:0]    w_s1      [NV];
    logic [NV-1:0]    w_s1_col  [NV];
    logic [NV-1:0]    w_s2      [NV];
    logic [NV-1:0]    w_win_row [NV];
    logic [NV-1:0]    w_in_win;
    logic [NV-1:0]    w_out_win;
    logic [IW-1:0]    w_in_idx  [NV];
    logic [IW-1:0]    w_out_own [NV];

    logic [NV-1:0]    w_busy_nxt;
    logic [NV-1:0]    w_in_alloc_nxt;
    logic [IW-1:0]    w_owner_nxt [NV];
    logic [NV*IW-1:0] w_gnt_vc_nxt;

    function automatic logic [IW-1:0] enc(input logic [NV-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int k = 0; k < int'(NV); k++) begin
            if (oh[k]) idx = idx | IW'(k);
        end
        return idx;
    endfunction

    // Busy outputs and already-served inputs drop out before arbitration.
    always_comb begin
        for (int i = 0; i < int'(NV); i++) begin
            w_ereq[i] = req_i[i*NV +: NV] & ~r_busy & {NV{~r_in_alloc[i]}};
        end
    end

    always_comb begin
        w_s1_col  = '{default: '0};
        w_win_row = '{default: '0};
        for (int i = 0; i < int'(NV); i++) begin
            for (int j = 0; j < int'(NV); j++) begin
                w_s1_col[j][i]  = w_s1[i][j];
                w_win_row[i][j] = w_s2[j][i];
            end
        end
    end

    for (genvar g = 0; g < int'(NV); g++) begin : g_arb
        va_sep_alloc_rr_arb #(.W(NV)) u_s1 (
            .clk (clk),
            .rst (rst),
            .req (w_ereq[g]),
            .upd (w_in_win[g]),
            .gnt (w_s1[g])
        );
        va_sep_alloc_rr_arb #(.W(NV)) u_s2 (
            .clk (clk),
            .rst (rst),
            .req (w_s1_col[g]),
            .upd (w_out_win[g]),
            .gnt (w_s2[g])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(NV); k++) begin
            w_in_win[k]  = |w_win_row[k];
            w_in_idx[k]  = enc(w_win_row[k]);
            w_out_win[k] = |w_s2[k];
            w_out_own[k] = enc(w_s2[k]);
        end
    end

    // Releases only touch busy outputs and grants only idle ones, so the two updates never collide.
    always_comb begin
        w_busy_nxt     = r_busy;
        w_in_alloc_nxt = r_in_alloc;
        w_owner_nxt    = r_owner;
        w_gnt_vc_nxt   = '0;
        for (int j = 0; j < int'(NV); j++) begin
            if (release_i[j] && r_busy[j]) begin
                w_busy_nxt[j]                 = 1'b0;
                w_in_alloc_nxt[r_owner[j]]    = 1'b0;
            end
            if (w_out_win[j]) begin
                w_busy_nxt[j]  = 1'b1;
                w_owner_nxt[j] = w_out_own[j];
            end
        end
        for (int i = 0; i < int'(NV); i++) begin
            if (w_in_win[i]) begin
                w_in_alloc_nxt[i]            = 1'b1;
                w_gnt_vc_nxt[i*IW +: IW]     = w_in_idx[i];
            end
        end
    end

    // NOTE: the owner array is a small flop bank, not RAM, so it is reset along with the rest of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_in_alloc  <= '0;
            r_owner     <= '{default: '0};
            r_gnt_valid <= '0;
            r_gnt_vc    <= '0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_in_alloc  <= w_in_alloc_nxt;
            r_owner     <= w_owner_nxt;
            r_gnt_valid <= w_in_win;
            r_gnt_vc    <= w_gnt_vc_nxt;
        end
    end

    assign gnt_valid_o = r_gnt_valid;
    assign gnt_vc_o    = r_gnt_vc;
    assign out_busy_o  = r_busy;
    assign in_alloc_o  = r_in_alloc;

endmodule

// File: tb/tb_va_sep_alloc.sv
// Directed self-checking bench for va_sep_alloc at N=5, V=4 (NV=20).
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_va_sep_alloc;

    localparam int NV = 20;
    localparam int IW = 5;
    localparam int RW = NV * NV;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] req;
    logic [NV-1:0] rel;
    logic [NV-1:0] gnt_valid_o;
    logic [NV*IW-1:0] gnt_vc_o;
    logic [NV-1:0] out_busy_o;
    logic [NV-1:0] in_alloc_o;

    int n_chk = 0;
    int n_err = 0;

    va_sep_alloc #(.N(5), .V(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .release_i   (rel),
        .gnt_valid_o (gnt_valid_o),
        .gnt_vc_o    (gnt_vc_o),
        .out_busy_o  (out_busy_o),
        .in_alloc_o  (in_alloc_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] oh(input int k);
        return 128'(1) << k;
    endfunction

    function automatic logic [127:0] field(input int i);
        logic [IW-1:0] f;
        f = IW'(gnt_vc_o >> (i*IW));
        return 128'(f);
    endfunction

    task automatic add_req(input int i, input int j);
        req = req | (RW'(1) << (i*NV + j));
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        rel = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_gnt_valid", 128'(gnt_valid_o), '0);
        check("rst_gnt_vc",    128'(gnt_vc_o),    '0);
        check("rst_out_busy",  128'(out_busy_o),  '0);
        check("rst_in_alloc",  128'(in_alloc_o),  '0);

        // Single request 3 -> 7, then hold it for 10 cycles
        add_req(3, 7);
        step();
        check("single_valid", 128'(gnt_valid_o), oh(3));
        check("single_vc",    field(3),          128'(7));
        check("single_busy",  128'(out_busy_o),  oh(7));
        check("single_alloc", 128'(in_alloc_o),  oh(3));
        for (int c = 0; c < 10; c++) begin
            step();
            check("hold_no_dup", 128'(gnt_valid_o), '0);
        end
        check("hold_alloc", 128'(in_alloc_o), oh(3));
        req = '0;
        rel = NV'(1) << 7;
        step();
        rel = '0;
        check("rel7_busy",  128'(out_busy_o), '0);
        check("rel7_alloc", 128'(in_alloc_o), '0);

        // Multi-request from input 0 for {4,5,6}
        add_req(0, 4); add_req(0, 5); add_req(0, 6);
        step();
        check("multi_valid", 128'(gnt_valid_o), oh(0));
        check("multi_vc",    field(0),          128'(4));
        check("multi_busy",  128'(out_busy_o),  oh(4));
        step();
        check("multi_no_dup", 128'(gnt_valid_o), '0);
        req = '0;
        rel = NV'(1) << 4;
        step();
        rel = '0;
        check("rel4_busy", 128'(out_busy_o), '0);
        add_req(0, 4); add_req(0, 5); add_req(0, 6);
        step();
        check("multi2_valid", 128'(gnt_valid_o), oh(0));
        check("multi2_vc",    field(0),          128'(5));
        check("multi2_busy",  128'(out_busy_o),  oh(5));
        req = '0;
        rel = NV'(1) << 5;
        step();
        rel = '0;

        // Output contention: inputs 1, 2, 9 all want output 12
        add_req(1, 12); add_req(2, 12); add_req(9, 12);
        step();
        check("cont1_valid", 128'(gnt_valid_o), oh(1));
        check("cont1_vc",    field(1),          128'(12));
        step();
        check("cont1_masked", 128'(gnt_valid_o), '0);
        rel = NV'(1) << 12;
        step();
        rel = '0;
        check("cont_rel_nogrant", 128'(gnt_valid_o), '0);
        check("cont_rel_busy",    128'(out_busy_o),  '0);
        step();
        check("cont2_valid", 128'(gnt_valid_o), oh(2));
        check("cont2_vc",    field(2),          128'(12));
        rel = NV'(1) << 12;
        step();
        rel = '0;
        check("cont_rel2_alloc", 128'(in_alloc_o), '0);
        step();
        check("cont3_valid", 128'(gnt_valid_o), oh(9));
        check("cont3_vc",    field(9),          128'(12));
        check("cont3_owner", 128'(in_alloc_o),  oh(9));

        // Release of 12 in the same cycle input 5 asks for it: no bypass
        req = '0;
        add_req(5, 12);
        rel = NV'(1) << 12;
        step();
        rel = '0;
        check("reltime_t1_valid", 128'(gnt_valid_o), '0);
        check("reltime_t1_busy",  128'(out_busy_o),  '0);
        step();
        check("reltime_t2_valid", 128'(gnt_valid_o), oh(5));
        check("reltime_t2_vc",    field(5),          128'(12));
        check("reltime_t2_busy",  128'(out_busy_o),  oh(12));

        // Stray release of idle output 15
        req = '0;
        rel = NV'(1) << 15;
        step();
        rel = '0;
        check("stray_busy",  128'(out_busy_o),  oh(12));
        check("stray_alloc", 128'(in_alloc_o),  oh(5));
        check("stray_valid", 128'(gnt_valid_o), '0);
        rel = NV'(1) << 12;
        step();
        rel = '0;
        check("clean_busy", 128'(out_busy_o), '0);

        // Reset while outputs 0-3 are owned, with a concurrent release
        for (int k = 0; k < 4; k++) add_req(k, k);
        step();
        check("pre_rst_busy",  128'(out_busy_o),  128'(20'hF));
        check("pre_rst_alloc", 128'(in_alloc_o),  128'(20'hF));
        req = '0;
        rst = 1'b1;
        rel = NV'(1) << 0;
        step();
        rst = 1'b0;
        rel = '0;
        check("midrst_gnt_valid", 128'(gnt_valid_o), '0);
        check("midrst_gnt_vc",    128'(gnt_vc_o),    '0);
        check("midrst_out_busy",  128'(out_busy_o),  '0);
        check("midrst_in_alloc",  128'(in_alloc_o),  '0);
        add_req(8, 2);
        step();
        check("postrst_valid", 128'(gnt_valid_o), oh(8));
        check("postrst_vc",    field(8),          128'(2));
        check("postrst_busy",  128'(out_busy_o),  oh(2));
        req = '0;
        step();
        check("postrst_pulse", 128'(gnt_valid_o), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
